// File: rtl/fixed_pkg.sv
// rtl/fixed_pkg.sv - shared state encoding and saturation constants for fixed-point stages
package fixed_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_NORM = 2'd2;

    // Wide enough for 2W+1-bit magnitudes up to W=63.
    localparam int WIDE_W = 128;
    typedef logic [WIDE_W-1:0] wide_t;

    function automatic int max(input int x, input int y);
        return (x > y) ? x : y;
    endfunction

    // Largest positive value of an n-bit signed number.
    function automatic wide_t sat_max(input int n);
        return (wide_t'(1) << (n - 1)) - wide_t'(1);
    endfunction

    // Bit pattern of the most negative n-bit signed number; equals its magnitude.
    function automatic wide_t sat_min(input int n);
        return wide_t'(1) << (n - 1);
    endfunction

endpackage

// File: rtl/fixed_round_sat.sv
// rtl/fixed_round_sat.sv - round half away from zero and saturate a sign/magnitude product
module fixed_round_sat
    import fixed_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int N    = 32
) (
    input  logic [2*W-1:0] p,
    input  logic           sign,
    output logic [N-1:0]   z,
    output logic           ov
);

    localparam int RW = 2 * W + 1;
    localparam int CW = max(RW, N + 1);
    localparam logic [RW-1:0] HALF    = RW'((wide_t'(1) << FRAC) >> 1);
    localparam logic [CW-1:0] POS_LIM = CW'(sat_max(N));
    localparam logic [CW-1:0] NEG_LIM = CW'(sat_min(N));
    localparam logic [N-1:0]  Z_MAX   = N'(sat_max(N));
    localparam logic [N-1:0]  Z_MIN   = N'(sat_min(N));

    logic [RW-1:0] w_sum;
    logic [RW-1:0] w_r;
    logic [CW-1:0] w_r_ext;
    logic [N-1:0]  w_r_n;

    // Extra top bit keeps the rounding carry out of a full-scale magnitude.
    assign w_sum   = {1'b0, p} + HALF;
    assign w_r     = w_sum >> FRAC;
    assign w_r_ext = CW'(w_r);
    assign w_r_n   = N'(w_r_ext);

    always_comb begin
        z  = w_r_n;
        ov = 1'b0;
        if (!sign) begin
            if (w_r_ext > POS_LIM) begin
                z  = Z_MAX;
                ov = 1'b1;
            end
        end else if (w_r_ext > NEG_LIM) begin
            z  = Z_MIN;
            ov = 1'b1;
        end else begin
            z = -w_r_n;
        end
    end

endmodule

// File: rtl/fixed_mul_seq.sv
// rtl/fixed_mul_seq.sv - radix-2 shift-add signed fixed-point multiplier with start/done handshake
module fixed_mul_seq
    import fixed_pkg::*;
#(
    parameter int W    = 32,
    parameter int FRAC = 16,
    parameter int N    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic                busy,
    output logic                done,
    output logic signed [N-1:0] z,
    output logic                ov
);

    localparam int CNT_W = max(1, $clog2(W));
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

    logic [1:0]       r_state;
    logic             r_sign;
    logic [2*W-1:0]   r_mcand;
    logic [W-1:0]     r_mplier;
    logic [2*W-1:0]   r_p;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [N-1:0]     r_z;
    logic             r_ov;

    logic [W-1:0]     w_abs_a;
    logic [W-1:0]     w_abs_b;
    logic [N-1:0]     w_z;
    logic             w_ov;

    // Unsigned W-bit magnitudes so the most negative operand stays exact.
    assign w_abs_a = a[W-1] ? $unsigned(-a) : $unsigned(a);
    assign w_abs_b = b[W-1] ? $unsigned(-b) : $unsigned(b);

    fixed_round_sat #(
        .W    (W),
        .FRAC (FRAC),
        .N    (N)
    ) u_round_sat (
        .p    (r_p),
        .sign (r_sign),
        .z    (w_z),
        .ov   (w_ov)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_sign   <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_p      <= '0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_z      <= '0;
            r_ov     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sign   <= a[W-1] ^ b[W-1];
                        r_mcand  <= {{W{1'b0}}, w_abs_a};
                        r_mplier <= w_abs_b;
                        r_p      <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    if (r_mplier[0]) begin
                        r_p <= r_p + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_NORM;
                    end
                end
                ST_NORM: begin
                    r_z     <= w_z;
                    r_ov    <= w_ov;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign z    = r_z;
    assign ov   = r_ov;

endmodule
